// File: rtl/ps_pwm_ctrl_pkg.sv
// Shared constants and FSM state type for the PS-PWM configuration sequencer.
package ps_pwm_pkg;

   localparam logic [3:0] ADDR_PERIOD = 4'h0;
   localparam logic [3:0] ADDR_DUTY0  = 4'h1;
   localparam logic [3:0] ADDR_COMMIT = 4'hE;
   localparam logic [3:0] ADDR_CTRL   = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PEND,
      ST_CALC,
      ST_APPLY
   } state_e;

endpackage

// File: rtl/ps_pwm_ctrl_if.sv
// Register-write port of the PS-PWM sequencer: valid/ready with address and data.
interface ps_pwm_ctrl_if #(
   parameter int CNT_W = 8
);

   logic             cfg_valid;
   logic             cfg_ready;
   logic [3:0]       cfg_addr;
   logic [CNT_W-1:0] cfg_data;

   modport master (
      output cfg_valid,
      output cfg_addr,
      output cfg_data,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_addr,
      input  cfg_data,
      output cfg_ready
   );

endinterface

// File: rtl/ps_pwm_ctrl_phase_calc.sv
// Sequential phase generator: phase_k = floor(k*period/N_CH), one channel per cycle.
module ps_pwm_phase_calc
   import ps_pwm_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int CNT_W = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start_i,
   input  logic [CNT_W-1:0]             period_i,
   output logic                         done_o,
   output logic [N_CH-1:0][CNT_W-1:0]   phase_tmp_o
);

   localparam int SH    = $clog2(N_CH);
   localparam int ACC_W = CNT_W + SH;

   logic [ACC_W-1:0]             acc_q;
   logic [SH-1:0]                k_q;
   logic                         busy_q;
   logic [N_CH-1:0][CNT_W-1:0]   tmp_q;

   // Accumulating period and shifting by log2(N_CH) avoids a divider.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q  <= '0;
         k_q    <= '0;
         busy_q <= 1'b0;
         tmp_q  <= '0;
      end else if (start_i) begin
         acc_q  <= '0;
         k_q    <= '0;
         busy_q <= 1'b1;
      end else if (busy_q) begin
         tmp_q[k_q] <= CNT_W'(acc_q >> SH);
         acc_q      <= acc_q + ACC_W'(period_i);
         k_q        <= k_q + 1'b1;
         if (k_q == '1) begin
            busy_q <= 1'b0;
         end
      end
   end

   assign done_o      = busy_q && (k_q == '1);
   assign phase_tmp_o = tmp_q;

endmodule

// File: rtl/ps_pwm_ctrl.sv
// PS-PWM configuration sequencer: shadow registers, commit FSM, atomic output bank.
// Define PS_PWM_CTRL_CLAMP_EN to clamp duties above the new period at apply time.
module ps_pwm_ctrl
   import ps_pwm_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   ps_pwm_ctrl_if.slave           cfg,
   input  logic                   sync_in,
   output logic                   run_o,
   output logic [CNT_W-1:0]       period_o,
   output logic [N_CH*CNT_W-1:0]  duty_o,
   output logic [N_CH*CNT_W-1:0]  phase_o,
   output logic                   upd_o,
   output logic                   err_o
);

   localparam logic [3:0] ADDR_DUTY_LAST = 4'(N_CH);

   state_e                       state_q, state_d;
   logic                         run_q, err_q;
   logic [CNT_W-1:0]             per_sh_q;
   logic [N_CH-1:0][CNT_W-1:0]   duty_sh_q;
   logic [CNT_W-1:0]             period_q;
   logic [N_CH-1:0][CNT_W-1:0]   duty_q, phase_q;
   logic [N_CH-1:0][CNT_W-1:0]   phase_tmp;
   logic                         xfer, is_duty, calc_start, calc_done;

   assign xfer    = cfg.cfg_valid && (state_q == ST_IDLE);
   assign is_duty = (cfg.cfg_addr >= ADDR_DUTY0) && (cfg.cfg_addr <= ADDR_DUTY_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      calc_start = 1'b0;
      upd_o      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (xfer && (cfg.cfg_addr == ADDR_COMMIT)) begin
               if (run_q) begin
                  state_d = ST_PEND;
               end else begin
                  state_d    = ST_CALC;
                  calc_start = 1'b1;
               end
            end
         end
         ST_PEND: begin
            if (sync_in) begin
               state_d    = ST_CALC;
               calc_start = 1'b1;
            end
         end
         ST_CALC: begin
            if (calc_done) begin
               state_d = ST_APPLY;
            end
         end
         ST_APPLY: begin
            upd_o   = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign cfg.cfg_ready = (state_q == ST_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q     <= 1'b0;
         err_q     <= 1'b0;
         per_sh_q  <= '1;
         duty_sh_q <= '0;
      end else if (xfer) begin
         if (cfg.cfg_addr == ADDR_PERIOD) begin
            per_sh_q <= cfg.cfg_data;
         end else if (is_duty) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
               if (cfg.cfg_addr == 4'(k + 1)) begin
                  duty_sh_q[k] <= cfg.cfg_data;
               end
            end
         end else if (cfg.cfg_addr == ADDR_CTRL) begin
            run_q <= cfg.cfg_data[0];
            if (cfg.cfg_data[1]) begin
               err_q <= 1'b0;
            end
         end else if (cfg.cfg_addr != ADDR_COMMIT) begin
            err_q <= 1'b1;
         end
      end
   end

   ps_pwm_phase_calc #(
      .N_CH  (N_CH),
      .CNT_W (CNT_W)
   ) u_phase_calc (
      .clk         (clk),
      .rst         (rst),
      .start_i     (calc_start),
      .period_i    (per_sh_q),
      .done_o      (calc_done),
      .phase_tmp_o (phase_tmp)
   );

   // Output bank loads only on the edge that ends APPLY.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_q <= '1;
         duty_q   <= '0;
         phase_q  <= '0;
      end else if (state_q == ST_APPLY) begin
         period_q <= per_sh_q;
         phase_q  <= phase_tmp;
         for (int unsigned k = 0; k < N_CH; k++) begin
`ifdef PS_PWM_CTRL_CLAMP_EN
            duty_q[k] <= (duty_sh_q[k] > per_sh_q) ? per_sh_q : duty_sh_q[k];
`else
            duty_q[k] <= duty_sh_q[k];
`endif
         end
      end
   end

   assign run_o    = run_q;
   assign err_o    = err_q;
   assign period_o = period_q;
   assign duty_o   = duty_q;
   assign phase_o  = phase_q;

endmodule

// File: tb/tb_ps_pwm_ctrl.sv
// Directed self-checking bench for ps_pwm_ctrl with an expected-output scoreboard.
module tb_ps_pwm_ctrl;

   localparam int N_CH  = 4;
   localparam int CNT_W = 8;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   sync_in;
   logic                   run_o, upd_o, err_o;
   logic [CNT_W-1:0]       period_o;
   logic [N_CH*CNT_W-1:0]  duty_o, phase_o;

   always #5 clk = ~clk;

   ps_pwm_ctrl_if #(.CNT_W(CNT_W)) cfg ();

   ps_pwm_ctrl #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .cfg      (cfg),
      .sync_in  (sync_in),
      .run_o    (run_o),
      .period_o (period_o),
      .duty_o   (duty_o),
      .phase_o  (phase_o),
      .upd_o    (upd_o),
      .err_o    (err_o)
   );

   typedef struct {
      logic [CNT_W-1:0]      per;
      logic [N_CH*CNT_W-1:0] duty;
      logic [N_CH*CNT_W-1:0] phase;
   } exp_t;

   exp_t             exp_q[$];
   exp_t             cur;
   int               errors = 0;
   int               checks = 0;
   logic [CNT_W-1:0] m_per;
   logic [CNT_W-1:0] m_duty [N_CH];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_per = '1;
      for (int k = 0; k < N_CH; k++) m_duty[k] = '0;
      cur.per   = '1;
      cur.duty  = '0;
      cur.phase = '0;
      exp_q.delete();
   endtask

   task automatic push_exp();
      exp_t e;
      logic [CNT_W-1:0] dv;
      e.per = m_per;
      for (int k = 0; k < N_CH; k++) begin
         dv = m_duty[k];
`ifdef PS_PWM_CTRL_CLAMP_EN
         if (dv > m_per) dv = m_per;
`endif
         e.duty[k*CNT_W +: CNT_W]  = dv;
         e.phase[k*CNT_W +: CNT_W] = CNT_W'((k * int'(m_per)) / N_CH);
      end
      exp_q.push_back(e);
   endtask

   task automatic wr(input logic [3:0] a, input logic [CNT_W-1:0] d);
      chk("ready_before_wr", 64'(cfg.cfg_ready), 64'd1);
      cfg.cfg_valid = 1'b1;
      cfg.cfg_addr  = a;
      cfg.cfg_data  = d;
      @(posedge clk); #1;
      cfg.cfg_valid = 1'b0;
      if (a == 4'h0) m_per = d;
      else if (a >= 4'd1 && a <= 4'(N_CH)) m_duty[int'(a) - 1] = d;
      else if (a == 4'hE) push_exp();
   endtask

   task automatic wait_apply(input string tag, input int exp_lat);
      int   n = 0;
      exp_t e;
      while (upd_o !== 1'b1 && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
      if (upd_o === 1'b1) begin
         chk({tag, "_hold_in_apply"}, 64'(period_o), 64'(cur.per));
         chk({tag, "_ready_in_apply"}, 64'(cfg.cfg_ready), 64'd0);
         @(posedge clk); #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_period"}, 64'(period_o), 64'(e.per));
            chk({tag, "_duty"},   64'(duty_o),   64'(e.duty));
            chk({tag, "_phase"},  64'(phase_o),  64'(e.phase));
            cur = e;
         end
         chk({tag, "_upd_low"},  64'(upd_o),         64'd0);
         chk({tag, "_ready_up"}, 64'(cfg.cfg_ready), 64'd1);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic ok;
      rst           = 1'b1;
      sync_in       = 1'b0;
      cfg.cfg_valid = 1'b0;
      cfg.cfg_addr  = '0;
      cfg.cfg_data  = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("rst_period", 64'(period_o), 64'hFF);
      chk("rst_duty",   64'(duty_o),   64'd0);
      chk("rst_phase",  64'(phase_o),  64'd0);
      chk("rst_run",    64'(run_o),    64'd0);
      chk("rst_ready",  64'(cfg.cfg_ready), 64'd1);
      chk("rst_err",    64'(err_o),    64'd0);
      chk("rst_upd",    64'(upd_o),    64'd0);

      // Stopped commit: no sync needed.
      wr(4'h0, 8'd200);
      wr(4'h1, 8'd50);
      wr(4'h2, 8'd100);
      wr(4'h3, 8'd150);
      wr(4'h4, 8'd200);
      chk("shadow_not_visible", 64'(period_o), 64'hFF);
      wr(4'hE, 8'd0);
      wait_apply("stopped", N_CH);

      // Running commit waits for sync_in.
      wr(4'hF, 8'h01);
      chk("run_set", 64'(run_o), 64'd1);
      wr(4'h0, 8'd100);
      wr(4'hE, 8'd0);
      ok = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         if (cfg.cfg_ready !== 1'b0 || upd_o !== 1'b0 || period_o !== cur.per ||
             duty_o !== cur.duty || phase_o !== cur.phase) ok = 1'b0;
      end
      chk("pend_hold", 64'(ok), 64'd1);
      sync_in = 1'b1;
      @(posedge clk); #1;
      sync_in = 1'b0;
      wait_apply("running", N_CH);

      // sync_in in IDLE must not start anything.
      sync_in = 1'b1;
      @(posedge clk); #1;
      sync_in = 1'b0;
      ok = 1'b1;
      repeat (8) begin
         if (upd_o !== 1'b0 || cfg.cfg_ready !== 1'b1) ok = 1'b0;
         @(posedge clk); #1;
      end
      chk("sync_idle_ignored", 64'(ok), 64'd1);

      // Duty above period.
      wr(4'hF, 8'h00);
      chk("run_clear", 64'(run_o), 64'd0);
      wr(4'h0, 8'd80);
      wr(4'h3, 8'd120);
      wr(4'hE, 8'd0);
      wait_apply("clamp", N_CH);

      // Bad address and error clear.
      wr(4'h9, 8'h5A);
      chk("bad_addr_err",    64'(err_o),    64'd1);
      chk("bad_addr_period", 64'(period_o), 64'(cur.per));
      chk("bad_addr_duty",   64'(duty_o),   64'(cur.duty));
      chk("bad_addr_run",    64'(run_o),    64'd0);
      wr(4'hF, 8'h03);
      chk("err_cleared", 64'(err_o), 64'd0);
      chk("run_by_ctrl", 64'(run_o), 64'd1);

      // Reset in the middle of CALC.
      wr(4'h9, 8'h00);
      wr(4'hF, 8'h00);
      wr(4'h0, 8'd33);
      wr(4'hE, 8'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_period", 64'(period_o), 64'hFF);
      chk("midrst_duty",   64'(duty_o),   64'd0);
      chk("midrst_phase",  64'(phase_o),  64'd0);
      chk("midrst_run",    64'(run_o),    64'd0);
      chk("midrst_err",    64'(err_o),    64'd0);
      chk("midrst_upd",    64'(upd_o),    64'd0);
      chk("midrst_ready",  64'(cfg.cfg_ready), 64'd1);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      wr(4'h0, 8'd60);
      wr(4'h2, 8'd7);
      wr(4'hE, 8'd0);
      wait_apply("post_reset", N_CH);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
